// File: rtl/sample_stream_player.sv
`default_nettype none
// ============================================================================
//  Module      : sample_stream_player
//  Description : Plays samples out of a small internal memory over a
//                valid/ready stream. Supports one-shot, loop and ping-pong
//                playback over the region 0..end_addr. A programmable number
//                of idle cycles is inserted after every accepted sample.
//  Ports       : clk, reset (sync, active-low)
//                wr_en/wr_addr/wr_data - memory load port (IDLE only)
//                start/stop            - playback control
//                mode/end_addr/rate_div - playback setup, latched on start
//                out_valid/out_ready/out_data/out_last - sample stream
//                busy - in PLAY, done - one-cycle end-of-playback pulse
//  Revision    : 1.0 - initial release
// ============================================================================
module sample_stream_player #(
  parameter int DATA_W = 16,
  parameter int DEPTH  = 32,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              start,
  input  logic              stop,
  input  logic [1:0]        mode,
  input  logic [ADDR_W-1:0] end_addr,
  input  logic [7:0]        rate_div,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              out_last,
  output logic              busy,
  output logic              done
);

  typedef enum logic [0:0] {
    S_IDLE = 1'b0,
    S_PLAY = 1'b1
  } state_t;

  localparam logic [1:0] c_MODE_LOOP = 2'b01;
  localparam logic [1:0] c_MODE_PP   = 2'b10;

  state_t             r_state;
  logic [DATA_W-1:0]  r_mem [DEPTH];
  logic [1:0]         r_mode;
  logic [ADDR_W-1:0]  r_end;
  logic [7:0]         r_rate;
  logic [ADDR_W-1:0]  r_addr;     // address of the presented (or pending) sample
  logic               r_dir;      // ping-pong direction, 1 = descending
  logic [7:0]         r_cnt;      // remaining idle cycles before next sample
  logic               r_out_valid;
  logic [DATA_W-1:0]  r_out_data;
  logic               r_out_last;
  logic               r_done;

  logic               w_pp;
  logic               w_oneshot;
  logic [ADDR_W-1:0]  w_next_addr;
  logic               w_next_dir;
  logic               w_next_last;
  logic               w_cur_last;

  // Next-address generation. In ping-pong the turning points are never
  // repeated: from E we go straight to E-1, from 0 straight to 1.
  always_comb begin
    w_pp        = (r_mode == c_MODE_PP);
    w_oneshot   = (r_mode != c_MODE_LOOP) && (r_mode != c_MODE_PP);
    w_next_addr = r_addr;
    w_next_dir  = r_dir;
    if (w_pp) begin
      if (!r_dir) begin
        if (r_addr == r_end) begin
          // end_addr == 0 degenerates to replaying address 0
          if (r_end != '0) begin
            w_next_addr = r_addr - 1'b1;
            w_next_dir  = 1'b1;
          end
        end else begin
          w_next_addr = r_addr + 1'b1;
        end
      end else begin
        if (r_addr == '0) begin
          w_next_addr = ADDR_W'(1);
          w_next_dir  = 1'b0;
        end else begin
          w_next_addr = r_addr - 1'b1;
        end
      end
    end else begin
      w_next_addr = (r_addr == r_end) ? '0 : r_addr + 1'b1;
    end
    // Address 0 only counts as a turning point after the first sample; the
    // first sample's flag is produced separately when playback starts.
    w_next_last = (w_next_addr == r_end) || (w_pp && (w_next_addr == '0));
    w_cur_last  = (r_addr == r_end) || (w_pp && (r_addr == '0));
  end

  // Sample memory: not reset, writable only while idle.
  always_ff @(posedge clk) begin
    if (wr_en && (r_state == S_IDLE)) begin
      r_mem[wr_addr] <= wr_data;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state     <= S_IDLE;
      r_mode      <= 2'b00;
      r_end       <= '0;
      r_rate      <= 8'd0;
      r_addr      <= '0;
      r_dir       <= 1'b0;
      r_cnt       <= 8'd0;
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_out_last  <= 1'b0;
      r_done      <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          r_out_valid <= 1'b0;
          r_out_last  <= 1'b0;
          if (start && !stop) begin
            r_mode      <= mode;
            r_end       <= end_addr;
            r_rate      <= rate_div;
            r_addr      <= '0;
            r_dir       <= 1'b0;
            r_cnt       <= 8'd0;
            r_out_valid <= 1'b1;
            r_out_data  <= r_mem[0];
            r_out_last  <= (end_addr == '0);
            r_state     <= S_PLAY;
          end
        end
        S_PLAY: begin
          if (stop) begin
            r_state     <= S_IDLE;
            r_out_valid <= 1'b0;
            r_out_last  <= 1'b0;
            r_done      <= 1'b1;
          end else if (r_out_valid && out_ready) begin
            if (w_oneshot && (r_addr == r_end)) begin
              r_state     <= S_IDLE;
              r_out_valid <= 1'b0;
              r_out_last  <= 1'b0;
              r_done      <= 1'b1;
            end else begin
              r_addr <= w_next_addr;
              r_dir  <= w_next_dir;
              if (r_rate == 8'd0) begin
                r_out_valid <= 1'b1;
                r_out_data  <= r_mem[w_next_addr];
                r_out_last  <= w_next_last;
              end else begin
                r_out_valid <= 1'b0;
                r_out_last  <= 1'b0;
                r_cnt       <= r_rate;
              end
            end
          end else if (!r_out_valid) begin
            // Idle gap: the sample appears on the edge that ends the last
            // idle cycle, giving exactly r_rate low cycles.
            if (r_cnt <= 8'd1) begin
              r_cnt       <= 8'd0;
              r_out_valid <= 1'b1;
              r_out_data  <= r_mem[r_addr];
              r_out_last  <= w_cur_last;
            end else begin
              r_cnt <= r_cnt - 8'd1;
            end
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign out_valid = r_out_valid;
  assign out_data  = r_out_data;
  assign out_last  = r_out_last;
  assign busy      = (r_state == S_PLAY);
  assign done      = r_done;

endmodule
`default_nettype wire

// File: tb/tb_sample_stream_player.sv
`default_nettype none
// ============================================================================
//  Module      : tb_sample_stream_player
//  Description : Directed self-checking bench for sample_stream_player.
//                Expected samples are queued as stimulus is set up and
//                compared as the stream delivers them.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_sample_stream_player;

  logic        clk;
  logic        reset;
  logic        wr_en;
  logic [4:0]  wr_addr;
  logic [15:0] wr_data;
  logic        start;
  logic        stop;
  logic [1:0]  mode;
  logic [4:0]  end_addr;
  logic [7:0]  rate_div;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_data;
  logic        out_last;
  logic        busy;
  logic        done;

  typedef struct packed {
    logic [15:0] data;
    logic        last;
  } exp_t;

  exp_t sb_q[$];
  int   checks = 0;
  int   errors = 0;
  bit   strict = 1'b0;

  sample_stream_player #(.DATA_W(16), .DEPTH(32)) dut (
    .clk      (clk),
    .reset    (reset),
    .wr_en    (wr_en),
    .wr_addr  (wr_addr),
    .wr_data  (wr_data),
    .start    (start),
    .stop     (stop),
    .mode     (mode),
    .end_addr (end_addr),
    .rate_div (rate_div),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data (out_data),
    .out_last (out_last),
    .busy     (busy),
    .done     (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input int d, input bit l);
    exp_t e;
    e.data = 16'(d);
    e.last = l;
    sb_q.push_back(e);
  endtask

  task automatic run_start(input logic [1:0] m, input logic [4:0] e, input logic [7:0] r);
    mode     = m;
    end_addr = e;
    rate_div = r;
    start    = 1'b1;
    tick();
    start    = 1'b0;
  endtask

  task automatic wait_empty(input int budget);
    for (int i = 0; i < budget && sb_q.size() != 0; i++) tick();
    chk("drain_queue_size", 32'(sb_q.size()), 32'd0);
  endtask

  task automatic finish_loop();
    strict    = 1'b0;
    out_ready = 1'b0;
    stop      = 1'b1;
    tick();
    chk("stop_done", 32'(done), 32'd1);
    chk("stop_busy", 32'(busy), 32'd0);
    chk("stop_valid", 32'(out_valid), 32'd0);
    stop = 1'b0;
    tick();
    sb_q.delete();
  endtask

  // Scoreboard side: every accepted sample is compared with the queue head.
  always @(negedge clk) begin
    if (out_valid && out_ready) begin
      if (sb_q.size() > 0) begin
        exp_t e;
        e = sb_q.pop_front();
        chk("sample_data", 32'(out_data), 32'(e.data));
        chk("sample_last", 32'(out_last), 32'(e.last));
      end else begin
        checks++;
        assert (!strict) else begin
          errors++;
          $error("FAIL unexpected_sample: observed %0h expected none", out_data);
        end
      end
    end
  end

  initial begin
    reset = 1'b0; wr_en = 1'b0; wr_addr = '0; wr_data = '0;
    start = 1'b0; stop = 1'b0; mode = 2'b00; end_addr = '0;
    rate_div = 8'd0; out_ready = 1'b0;
    repeat (2) tick();

    // Reset state
    chk("rst_valid", 32'(out_valid), 32'd0);
    chk("rst_last", 32'(out_last), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_data", 32'(out_data), 32'd0);

    reset = 1'b1;
    tick();
    for (int k = 0; k < 32; k++) begin
      wr_en = 1'b1; wr_addr = 5'(k); wr_data = 16'(k + 100);
      tick();
    end
    wr_en = 1'b0;

    // One-shot, end 3, full rate
    out_ready = 1'b1; strict = 1'b1;
    for (int k = 0; k < 4; k++) push(100 + k, k == 3);
    run_start(2'b00, 5'd3, 8'd0);
    chk("os_first_valid", 32'(out_valid), 32'd1);
    chk("os_busy", 32'(busy), 32'd1);
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("os_consecutive_valid", 32'(out_valid), 32'd1);
    end
    tick();
    chk("os_done", 32'(done), 32'd1);
    chk("os_end_busy", 32'(busy), 32'd0);
    chk("os_end_valid", 32'(out_valid), 32'd0);
    chk("os_queue", 32'(sb_q.size()), 32'd0);
    tick();
    chk("os_done_pulse", 32'(done), 32'd0);

    // Ping-pong, end 2
    strict = 1'b1; out_ready = 1'b1;
    push(100, 0); push(101, 0); push(102, 1); push(101, 0);
    push(100, 1); push(101, 0); push(102, 1);
    run_start(2'b10, 5'd2, 8'd0);
    wait_empty(40);
    finish_loop();

    // Loop, end 31, rate 2; setup changes, start and writes mid-play ignored
    strict = 1'b1; out_ready = 1'b1;
    for (int k = 0; k < 32; k++) push(100 + k, k == 31);
    push(100, 0); push(101, 0);
    run_start(2'b01, 5'd31, 8'd2);
    chk("rate_pat0", 32'(out_valid), 32'd1);
    tick(); chk("rate_pat1", 32'(out_valid), 32'd0);
    tick(); chk("rate_pat2", 32'(out_valid), 32'd0);
    tick(); chk("rate_pat3", 32'(out_valid), 32'd1);
    mode = 2'b10; end_addr = 5'd1; rate_div = 8'd0; start = 1'b1;
    wr_en = 1'b1; wr_addr = 5'd5; wr_data = 16'hDEAD;
    tick();
    start = 1'b0; wr_en = 1'b0;
    wait_empty(200);
    finish_loop();

    // Loop with backpressure on sample 101
    strict = 1'b1; out_ready = 1'b1;
    push(100, 0); push(101, 0); push(102, 0); push(103, 1); push(100, 0);
    run_start(2'b01, 5'd3, 8'd0);
    tick();
    out_ready = 1'b0;
    for (int k = 0; k < 5; k++) begin
      tick();
      chk("bp_valid", 32'(out_valid), 32'd1);
      chk("bp_data", 32'(out_data), 32'd101);
    end
    out_ready = 1'b1;
    wait_empty(20);
    finish_loop();

    // Reset mid-loop at sample 105, then restart
    strict = 1'b1; out_ready = 1'b1;
    for (int k = 0; k < 5; k++) push(100 + k, 0);
    run_start(2'b01, 5'd31, 8'd0);
    repeat (5) tick();
    chk("pre_rst_data", 32'(out_data), 32'd105);
    out_ready = 1'b0; reset = 1'b0;
    tick();
    chk("midrst_valid", 32'(out_valid), 32'd0);
    chk("midrst_busy", 32'(busy), 32'd0);
    chk("midrst_data", 32'(out_data), 32'd0);
    chk("midrst_last", 32'(out_last), 32'd0);
    reset = 1'b1; out_ready = 1'b1;
    for (int k = 0; k < 7; k++) push(100 + k, 0);
    run_start(2'b01, 5'd31, 8'd0);
    wait_empty(20);
    finish_loop();

    // Stop while stalled
    strict = 1'b1; out_ready = 1'b0;
    run_start(2'b00, 5'd3, 8'd0);
    chk("stall_valid", 32'(out_valid), 32'd1);
    chk("stall_data", 32'(out_data), 32'd100);
    stop = 1'b1;
    tick();
    chk("stall_stop_busy", 32'(busy), 32'd0);
    chk("stall_stop_done", 32'(done), 32'd1);
    chk("stall_stop_valid", 32'(out_valid), 32'd0);
    stop = 1'b0; out_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      tick();
      chk("after_stop_valid", 32'(out_valid), 32'd0);
    end

    // end_addr 0: ping-pong repeats mem[0], reserved mode plays once
    strict = 1'b1; out_ready = 1'b1;
    for (int k = 0; k < 4; k++) push(100, 1);
    run_start(2'b10, 5'd0, 8'd0);
    wait_empty(20);
    finish_loop();
    strict = 1'b1; out_ready = 1'b1;
    push(100, 1);
    run_start(2'b11, 5'd0, 8'd0);
    tick();
    chk("os0_done", 32'(done), 32'd1);
    chk("os0_busy", 32'(busy), 32'd0);

    // start together with stop in IDLE
    start = 1'b1; stop = 1'b1;
    tick();
    start = 1'b0; stop = 1'b0;
    chk("startstop_busy", 32'(busy), 32'd0);
    tick();
    chk("startstop_valid", 32'(out_valid), 32'd0);

    // Ping-pong across the full memory
    strict = 1'b1; out_ready = 1'b1;
    for (int k = 0; k < 32; k++) push(100 + k, k == 31);
    for (int k = 30; k >= 0; k--) push(100 + k, k == 0);
    push(101, 0);
    run_start(2'b10, 5'd31, 8'd0);
    wait_empty(100);
    finish_loop();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/sample_stream_player.md
SAMPLE_STREAM_PLAYER -- requirements
Module: sample_stream_player

Interface
REQ-001 Parameter DATA_W, default 16, sample width in bits.
REQ-002 Parameter DEPTH, default 32, sample memory entries (power of two, >=2).
REQ-003 Parameter ADDR_W, default clog2(DEPTH), address width.
REQ-004 clk  in  1  sole clock; all logic on rising edge.
REQ-005 reset  in  1  synchronous, active-low reset; sampled on rising edge of clk.
REQ-006 wr_en  in  1  load strobe for sample memory.
REQ-007 wr_addr  in  ADDR_W  load address.
REQ-008 wr_data  in  DATA_W  load data.
REQ-009 start  in  1  begin playback (single-cycle pulse or level; edge not required).
REQ-010 stop  in  1  abort playback.
REQ-011 mode  in  2  00 one-shot, 01 loop, 10 ping-pong, 11 reserved (treated as one-shot).
REQ-012 end_addr  in  ADDR_W  last address of the played region (region is 0..end_addr).
REQ-013 rate_div  in  8  minimum idle cycles inserted between consecutive accepted samples.
REQ-014 out_valid  out  1  out_data holds a sample.
REQ-015 out_ready  in  1  downstream accepts when out_valid && out_ready.
REQ-016 out_data  out  DATA_W  sample value.
REQ-017 out_last  out  1  qualifies the sample at end_addr (one-shot/loop) or at either turning point (ping-pong).
REQ-018 busy  out  1  high in PLAY state.
REQ-019 done  out  1  one-cycle pulse when one-shot completes or stop aborts.

Function
REQ-020 States SHALL be IDLE and PLAY; done is a registered pulse on the PLAY->IDLE transition.
REQ-021 Memory writes SHALL occur only in IDLE (wr_en in PLAY ignored); write visible to a playback started next cycle.
REQ-022 IDLE + start (stop low) SHALL latch mode, end_addr, rate_div, set addr=0, enter PLAY; out_valid=1 with out_data=mem[0] on the following cycle (latency 1).
REQ-023 start while in PLAY SHALL be ignored; changes to mode/end_addr/rate_div during PLAY SHALL have no effect.
REQ-024 While out_valid && !out_ready, out_data, out_last and out_valid SHALL hold stable.
REQ-025 After a transfer, out_valid SHALL stay low for exactly rate_div cycles, then assert with the next sample; rate_div=0 gives one sample per cycle under constant out_ready.
REQ-026 One-shot: addresses 0..end_addr once; transfer of end_addr sample (out_last=1) SHALL return to IDLE with out_valid=0 and done=1 next cycle.
REQ-027 Loop: after end_addr, address SHALL wrap to 0 indefinitely.
REQ-028 Ping-pong: 0,1..E,E-1..1,0,1..; turning points SHALL not repeat; out_last=1 at E and at 0 (except the first sample).
REQ-029 end_addr=0 SHALL play mem[0] repeatedly (loop/ping-pong) or once (one-shot), out_last=1 on every such sample.
REQ-030 stop in PLAY SHALL enter IDLE next cycle, drop out_valid, pulse done, regardless of out_ready; stop and start together in IDLE: stop wins, no playback.
REQ-031 Address arithmetic SHALL be ADDR_W bits; end_addr=DEPTH-1 SHALL wrap correctly without overflow.

Reset
REQ-032 reset=0 at a rising edge SHALL force IDLE, out_valid=0, out_last=0, busy=0, done=0, out_data=0, addr=0, divider counter=0, from any state including mid-playback.
REQ-033 Memory contents SHALL be unaffected by reset.

Verification
REQ-034 Load mem[k]=k+100 for k=0..31, mode=00, end_addr=3, rate_div=0, out_ready=1, pulse start -> out_data 100,101,102,103 on consecutive cycles, out_last with 103, done next cycle, busy low.
REQ-035 Same load, mode=10, end_addr=2 -> sequence 100,101,102,101,100,101,102; out_last on 102,100,102.
REQ-036 mode=01, end_addr=31, rate_div=2 -> out_valid pattern 1,0,0,1..., 131 followed by 100.
REQ-037 mode=01, out_ready held low 5 cycles on sample 101 -> out_data=101 stable, no skip, next 102 after release.
REQ-038 reset=0 during loop playback at sample 105 -> next cycle out_valid=0, busy=0; restart yields 100 first, memory intact.
REQ-039 stop asserted with out_valid && !out_ready -> IDLE next cycle, done=1, no further samples; wr_en during PLAY leaves memory unchanged.
